stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//   Parametrised N_CH-input, W-bit registered stream multiplexer with a valid/ready handshake on every port.
//   Two modes: explicit select (sel picks the source) or round-robin arbitration across all valid inputs.
//   Generalises the combinational 2:1/4:1 mux cells to arbitrary channel count and data width.
//   Adds a one-entry output register so it can sit on datapath stream boundaries.
// PARAMETERS
//   N_CH   4                 number of input channels, >=2; need not be a power of two
//   W      8                 data width per channel, >=1
//   SELW   $clog2(N_CH)      localparam: width of sel and out_ch
// PORTS
//   clk        in   1         single clock; all state on the rising edge
//   rst_n      in   1         asynchronous, active-low reset
//   mode       in   1         0 = MODE_SEL (use sel), 1 = MODE_RR (round-robin)
//   sel        in   SELW      source channel in MODE_SEL
//   in_valid   in   N_CH      per-channel valid
//   in_data    in   N_CH*W    flat data; channel i occupies bits [i*W +: W]
//   in_ready   out  N_CH      per-channel ready; at most one bit high per cycle
//   out_valid  out  1         output register holds a word
//   out_data   out  W         registered data
//   out_ch     out  SELW      channel index that supplied out_data
//   out_ready  in   1         downstream accepts the word
// BEHAVIOUR
//   Reset: asserting rst_n low immediately forces out_valid=0, out_data=0, out_ch=0 and rr_ptr=0, regardless of the clock.
//   Output FSM, 2 states encoded by out_valid:
//     EMPTY -> FULL on a grant.
//     FULL  -> FULL on (out_ready & grant), re-loading in the same cycle.
//     FULL  -> EMPTY on (out_ready & !grant).
//   can_load = !out_valid | out_ready. A combinational path from out_ready to in_ready is intended.
//   Grant, MODE_SEL:
//     granted iff sel < N_CH and in_valid[sel]; gnt_idx = sel.
//     sel >= N_CH never grants.
//   Grant, MODE_RR:
//     gnt_idx = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... N_CH-1, 0, ... rr_ptr-1.
//     No grant if in_valid == 0.
//   in_ready[i] = grant & can_load & (gnt_idx == i). The transfer on channel i is in_valid[i] & in_ready[i].
//   On a transfer, at the next edge:
//     out_data <= in_data[gnt_idx]; out_ch <= gnt_idx; out_valid <= 1.
//   Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle with out_ready held high.
//   rr_ptr:
//     In MODE_RR, on each transfer, rr_ptr <= (gnt_idx == N_CH-1) ? 0 : gnt_idx+1.
//     Unchanged in MODE_SEL and on cycles with no transfer.
//   Stability: while out_valid & !out_ready, out_data and out_ch hold, and in_ready = 0.
//   Mode or sel change: affects only the current cycle's grant. An already registered word is unaffected.
//     rr_ptr is preserved across mode switches.
//   Inputs that are not granted must not be consumed. Their data may change freely.
//   Reset asserted mid-transfer: the registered word is discarded and no in_ready is high during reset.
//     The first grant after deassertion uses rr_ptr = 0.
// STRUCTURE
//   Package mux_pkg:
//     typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_e
//   Sub-module rr_pick #(N_CH):
//     combinational rotate-priority find-first.
//     Inputs: req[N_CH] and ptr[SELW]. Outputs: found and idx[SELW].
//     Handles non-power-of-two N_CH.
//   Top level: select/grant mux, data mux, output register, rr_ptr register.
// TESTING  (N_CH=4, W=8 unless stated; per-channel data = {4'hC, ch} unless stated)
//   1 Async reset: rst_n=0 mid-stream, between clock edges -> out_valid=0, out_ch=0 at once.
//     After release in MODE_RR with all inputs valid -> first out_ch=0.
//   2 MODE_SEL: sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100.
//     Next cycle out_valid=1, out_data=8'hA5, out_ch=2.
//   3 MODE_RR: in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
//   4 MODE_RR: in_valid=4'b1010 -> out_ch 1,3,1,3; in_ready never high on ch0 or ch2.
//   5 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data/out_ch stable.
//     Then out_ready=1 -> the next word loads in the same cycle; no loss or duplication.
//   6 N_CH=3: sel=2'd3 -> no in_ready, out_valid stays 0.
//     MODE_RR with all valid -> out_ch 0,1,2,0 (wraps at 2).

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the stream multiplexer
package mux_pkg;
  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;
  function automatic int wrap(input int c, input int n);
    return (c >= n) ? c - n : c;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority find-first over req, starting at ptr
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);
  // Scan farthest-first so the candidate nearest ptr wins; ptr is always < N_CH.
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k, N_CH)]) begin
        found = 1'b1;
        idx = SELW'(wrap(int'(ptr) + k, N_CH));
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input registered stream mux with explicit-select or round-robin grant
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mux_mode_e         mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);
  out_state_e state, state_nx;
  logic [SELW-1:0] rr_ptr, pick_idx, gnt_idx;
  logic pick_found, grant, can_load, xfer;
  rr_pick #(.N_CH(N_CH)) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign out_valid = (state == FULL);
  assign can_load = !out_valid || out_ready;
  assign gnt_idx = (mode == MODE_RR) ? pick_idx : sel;
  assign grant = (mode == MODE_RR) ? pick_found : (int'(sel) < N_CH) && in_valid[sel];
  // rst_n gate keeps every in_ready low while reset is held
  assign xfer = grant && can_load && rst_n;
  assign in_ready = xfer ? (N_CH'(1) << gnt_idx) : '0;
  always_comb state_nx = can_load ? (xfer ? FULL : EMPTY) : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        out_data <= in_data[gnt_idx*W +: W];
        out_ch <= gnt_idx;
        if (mode == MODE_RR) rr_ptr <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + SELW'(1);
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench driving a 4-channel and a 3-channel mux from shared stimulus
module tb_stream_mux_rr;
  import mux_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  mux_mode_e mode = MODE_SEL;
  logic [1:0] sel = '0;
  logic [3:0] in_valid = '0;
  logic [31:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [3:0] in_ready4;
  logic [2:0] in_ready3;
  logic out_valid4, out_valid3;
  logic [7:0] out_data4, out_data3;
  logic [1:0] out_ch4, out_ch3;
  int n_chk = 0;
  int n_pass = 0;
  int ptr0 = 0;
  int ptr1 = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4), .out_ready(out_ready)
  );
  stream_mux_rr #(.N_CH(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid[2:0]), .in_data(in_data[23:0]), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference grant: first valid channel scanning circularly from p, or the selected one.
  function automatic int gnt(input mux_mode_e m, input logic [1:0] s, input logic [3:0] v,
                             input int p, input int n);
    if (m == MODE_RR) begin
      for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
      return -1;
    end
    return (int'(s) < n && v[s]) ? int'(s) : -1;
  endfunction

  task automatic step(input mux_mode_e m, input logic [1:0] s, input logic [3:0] v,
                      input logic r, input logic [31:0] d);
    int g0, g1;
    bit p0, p1;
    logic [15:0] e0, e1;
    @(negedge clk);
    mode = m;
    sel = s;
    in_valid = v;
    out_ready = r;
    in_data = d;
    #2;
    g0 = gnt(m, s, v, ptr0, 4);
    g1 = gnt(m, s, v, ptr1, 3);
    p0 = g0 >= 0 && (q0.size() == 0 || r);
    p1 = g1 >= 0 && (q1.size() == 0 || r);
    check("in_ready4", 32'(in_ready4), p0 ? 32'(1) << g0 : 32'(0));
    check("in_ready3", 32'(in_ready3), p1 ? 32'(1) << g1 : 32'(0));
    e0 = '0;
    e1 = '0;
    if (p0) begin
      e0 = {8'(g0), d[g0*8 +: 8]};
      if (m == MODE_RR) ptr0 = (g0 + 1) % 4;
    end
    if (p1) begin
      e1 = {8'(g1), d[g1*8 +: 8]};
      if (m == MODE_RR) ptr1 = (g1 + 1) % 3;
    end
    @(posedge clk);
    #1;
    if (p0) q0.push_back(e0);
    if (p1) q1.push_back(e1);
  endtask

  // Monitor: the head of each queue must be on the output while it is valid, popped on acceptance.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      check("out_valid4", 32'(out_valid4), 32'(q0.size() != 0));
      if (out_valid4 && q0.size() != 0) begin
        check("out_ch4", 32'(out_ch4), 32'(q0[0][15:8]));
        check("out_data4", 32'(out_data4), 32'(q0[0][7:0]));
        if (out_ready) void'(q0.pop_front());
      end
      check("out_valid3", 32'(out_valid3), 32'(q1.size() != 0));
      if (out_valid3 && q1.size() != 0) begin
        check("out_ch3", 32'(out_ch3), 32'(q1[0][15:8]));
        check("out_data3", 32'(out_data3), 32'(q1[0][7:0]));
        if (out_ready) void'(q1.pop_front());
      end
    end
  end

  localparam logic [31:0] DEF = 32'hC3C2C1C0;

  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid4", 32'(out_valid4), 32'(0));
    check("rst_data4", 32'(out_data4), 32'(0));
    check("rst_ch4", 32'(out_ch4), 32'(0));
    check("rst_valid3", 32'(out_valid3), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(MODE_SEL, 2'd2, 4'b1111, 1'b1, 32'hC3A5C1C0);
    step(MODE_SEL, 2'd0, 4'b0000, 1'b1, DEF);
    repeat (6) step(MODE_RR, 2'd0, 4'b1111, 1'b1, DEF);
    repeat (4) step(MODE_RR, 2'd0, 4'b1010, 1'b1, DEF);
    step(MODE_RR, 2'd0, 4'b1111, 1'b1, DEF);
    repeat (3) step(MODE_RR, 2'd0, 4'b1111, 1'b0, $urandom);
    repeat (3) step(MODE_RR, 2'd0, 4'b1111, 1'b1, $urandom);
    step(MODE_SEL, 2'd3, 4'b1111, 1'b1, DEF);
    step(MODE_SEL, 2'd3, 4'b1111, 1'b1, DEF);
    step(MODE_SEL, 2'd0, 4'b0000, 1'b1, DEF);
    repeat (300)
      step(mux_mode_e'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
           1'($urandom_range(0, 3) != 0), $urandom);
    step(MODE_RR, 2'd0, 4'b1111, 1'b0, DEF);
    step(MODE_RR, 2'd0, 4'b1111, 1'b0, DEF);
    mode = MODE_RR;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid4", 32'(out_valid4), 32'(0));
    check("mid_rst_ch4", 32'(out_ch4), 32'(0));
    check("mid_rst_rdy4", 32'(in_ready4), 32'(0));
    check("mid_rst_valid3", 32'(out_valid3), 32'(0));
    check("mid_rst_rdy3", 32'(in_ready3), 32'(0));
    q0.delete();
    q1.delete();
    ptr0 = 0;
    ptr1 = 0;
    in_valid = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step(MODE_RR, 2'd0, 4'b1111, 1'b1, DEF);
    repeat (3) step(MODE_SEL, 2'd0, 4'b0000, 1'b1, DEF);
    check("drained4", 32'(q0.size()), 32'(0));
    check("drained3", 32'(q1.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
